daq_arbiter: RTL

DAQ_ARBITER -- requirements
Module: daq_arbiter

---
 rtl/daq_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/daq_arbiter.sv
// -----------------------------------------------------------------------------
// daq_arbiter
//   Four-source data-acquisition merger. Each source owns a FIFO_DEPTH-word
//   FIFO. A round-robin arbiter drains the FIFOs into a single registered
//   output word with a valid/ready handshake.
//
// Ports
//   clk_daq    in   1   DAQ clock, rising edge
//   reset_n    in   1   synchronous active-low reset
//   run        in   1   acquisition enable; low flushes all FIFOs
//   src_write  in   4   per-source write strobe
//   src_data   in  64   per-source data, source k at [16k+15:16k]
//   out_write  out  1   output word valid
//   out_data   out 16   output word
//   out_ready  in   1   sink accepts the word this cycle
//   ovf        out  4   sticky per-source overflow flags
//   busy       out  1   any FIFO (or marker) pending, or out_write high
//
// Build option
//   DAQ_ARB_OVF_MARKER_EN : a dropped write on source k queues a 16'hEF0k
//   marker word for that source. Undefined by default (no markers).
// -----------------------------------------------------------------------------
module daq_arbiter #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_daq,
    input  logic        reset_n,
    input  logic        run,
    input  logic [3:0]  src_write,
    input  logic [63:0] src_data,
    output logic        out_write,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic [3:0]  ovf,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // FIFO storage and bookkeeping
    logic [3:0][FIFO_DEPTH-1:0][15:0] mem_q;
    ptr_t [3:0] wr_ptr_q, wr_ptr_d;
    ptr_t [3:0] rd_ptr_q, rd_ptr_d;
    cnt_t [3:0] cnt_q, cnt_d;

    // Output register
    logic        out_write_q, out_write_d;
    logic [15:0] out_data_q, out_data_d;

    // Arbiter / status state
    logic [1:0]  last_grant_q, last_grant_d;
    logic [3:0]  ovf_q, ovf_d;
    logic        run_q;

    // Combinational control
    logic [3:0]  nonempty;
    logic [3:0]  req;
    logic [3:0]  emit;
    logic [3:0]  push, pop, drop;
    logic        load_en;
    logic        gnt_vld;
    logic        grant;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic        run_rise;
    logic        mark_pend;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nonempty[k] = (cnt_q[k] != '0);
        end
    end

    assign run_rise = run & ~run_q;

    // The output register may take a new word when it is empty or its
    // current word is leaving this cycle.
    assign load_en = run & (~out_write_q | out_ready);

`ifdef DAQ_ARB_OVF_MARKER_EN
    logic [3:0] mark_q, mark_d;

    // A marker stands in for the first lost word, so it goes out once the
    // words that were accepted before the drop have drained.
    assign req       = nonempty | mark_q;
    assign emit      = mark_q & ~nonempty;
    assign mark_pend = |mark_q;

    always_comb begin
        mark_d = mark_q | drop;
        if (grant && emit[gnt_idx]) begin
            mark_d[gnt_idx] = 1'b0;
        end
        if (!run) begin
            mark_d = '0;
        end
    end

    always_ff @(posedge clk_daq) begin
        if (!reset_n) begin
            mark_q <= '0;
        end else begin
            mark_q <= mark_d;
        end
    end
`else
    assign req       = nonempty;
    assign emit      = '0;
    assign mark_pend = 1'b0;
`endif

    // Round-robin search starting at last_grant+1; the 4th candidate wraps
    // back to last_grant itself.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_grant_q;
        cand    = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = 2'(last_grant_q + 2'(i));
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = load_en & gnt_vld;

    // FIFO next state. A pop in the same cycle frees the slot a write to a
    // full FIFO needs, so that write is accepted.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push     = '0;
        pop      = '0;
        drop     = '0;
        for (int k = 0; k < 4; k++) begin
            pop[k]  = grant && (gnt_idx == 2'(k)) && !emit[k];
            push[k] = run && src_write[k] &&
                      ((cnt_q[k] != cnt_t'(FIFO_DEPTH)) || pop[k]);
            drop[k] = run && src_write[k] && !push[k];
            if (push[k]) begin
                wr_ptr_d[k] = wr_ptr_q[k] + ptr_t'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + ptr_t'(1);
            end
            cnt_d[k] = cnt_q[k] + cnt_t'(push[k]) - cnt_t'(pop[k]);
            if (!run) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                cnt_d[k]    = '0;
            end
        end
    end

    // Output register, arbiter pointer and overflow flags
    always_comb begin
        out_write_d  = out_write_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        ovf_d        = (run_rise ? 4'b0000 : ovf_q) | drop;
        if (!run) begin
            out_write_d = 1'b0;
        end else if (load_en) begin
            out_write_d = gnt_vld;
            if (gnt_vld) begin
                last_grant_d = gnt_idx;
                if (emit[gnt_idx]) begin
                    out_data_d = {14'(16'hEF00 >> 2), gnt_idx};
                end else begin
                    out_data_d = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
                end
            end
        end
    end

    always_ff @(posedge clk_daq) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            out_write_q  <= 1'b0;
            out_data_q   <= 16'h0000;
            last_grant_q <= 2'd3;
            ovf_q        <= '0;
            run_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            out_write_q  <= out_write_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            run_q        <= run;
        end
    end

    // Storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge clk_daq) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= src_data[16*k +: 16];
            end
        end
    end

    assign out_write = out_write_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign busy      = (|nonempty) | out_write_q | mark_pend;

endmodule
